alu_seq: RTL and testbench

Parametrised, handshaked, multi-cycle successor to the single-cycle datapath ALU. Adds bitwise XOR, set-less-than (signed and unsigned) and shifts, with valid/ready flow control on both sides. Shifts run iteratively at one bit per cycle, which keeps area small. Sits between the register-read stage and writeback; the control FSM stalls while in_ready is low.

---
 rtl/alu_seq.sv | 217 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU (AND/OR/ADD/SUB/XOR/SLT/SLTU/SLL/SRL/SRA).
// Shifts are iterative, one bit per clock.
// Optional multiplier enabled by the ALU_SEQ_MUL_EN macro (opcode 1010, radix-2 shift-add).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for an operation, in_ready high
// S_SHIFT | iterative shift, one bit per cycle, counter running down
// S_MUL   | shift-add multiply, one multiplier bit per cycle (macro only)
// S_DONE  | result presented with out_valid, held until out_ready
module alu_seq #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] operation_control,
    input  logic [WIDTH-1:0]    source_A,
    input  logic [WIDTH-1:0]    source_B,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    operation_output,
    output logic                zero,
    output logic                busy
);

    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(4'b0000);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(4'b0001);
    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(4'b0010);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(4'b0011);
    localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(4'b0100);
    localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(4'b0101);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(4'b0110);
    localparam logic [OP_WIDTH-1:0] OP_SRA  = OP_WIDTH'(4'b0111);
    localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(4'b1000);
    localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(4'b1001);
`ifdef ALU_SEQ_MUL_EN
    localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(4'b1010);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
`ifdef ALU_SEQ_MUL_EN
        S_MUL   = 2'd3,
`endif
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [OP_WIDTH-1:0]  op_q, op_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;

    logic [WIDTH-1:0]     alu_res;
    logic [WIDTH-1:0]     shift_step;
    logic [SHAMT_W-1:0]   shamt;
    logic                 is_shift;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mul_sum;
`endif

    assign shamt    = source_B[SHAMT_W-1:0];
    assign is_shift = (operation_control == OP_SLL) ||
                      (operation_control == OP_SRL) ||
                      (operation_control == OP_SRA);

    // Single-cycle result for every non-iterative opcode; a zero-amount shift passes A through.
    always_comb begin
        alu_res = '0;
        case (operation_control)
            OP_AND:  alu_res = source_A & source_B;
            OP_OR:   alu_res = source_A | source_B;
            OP_ADD:  alu_res = source_A + source_B;
            OP_SUB:  alu_res = source_A - source_B;
            OP_XOR:  alu_res = source_A ^ source_B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(source_A) < $signed(source_B))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (source_A < source_B)};
            OP_SLL,
            OP_SRL,
            OP_SRA:  alu_res = source_A;
            default: alu_res = '0;
        endcase
    end

    // One-bit step of the working register for the latched shift opcode.
    always_comb begin
        shift_step = work_q;
        case (op_q)
            OP_SLL:  shift_step = {work_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_step = {1'b0, work_q[WIDTH-1:1]};
            OP_SRA:  shift_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shift_step = work_q;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // Partial-product accumulate: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        mul_sum = acc_q + (mplier_q[0] ? work_q : '0);
    end
`endif

    // Next-state and datapath-next logic; result and zero change only when a result is produced.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef ALU_SEQ_MUL_EN
        mplier_d = mplier_q;
        acc_d    = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = operation_control;
                    if (is_shift && (shamt != '0)) begin
                        work_d  = source_A;
                        cnt_d   = shamt;
                        state_d = S_SHIFT;
                    end
`ifdef ALU_SEQ_MUL_EN
                    else if (operation_control == OP_MUL) begin
                        work_d   = source_A;
                        mplier_d = source_B;
                        acc_d    = '0;
                        cnt_d    = SHAMT_W'(WIDTH - 1);
                        state_d  = S_MUL;
                    end
`endif
                    else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                work_d = shift_step;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = shift_step;
                    zero_d   = (shift_step == '0);
                    state_d  = S_DONE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                acc_d    = mul_sum;
                work_d   = {work_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - SHAMT_W'(1);
                // Counter runs WIDTH-1 down to 0, so the last bit is consumed on the zero count.
                if (cnt_q == '0) begin
                    result_d = mul_sum;
                    zero_d   = (mul_sum == '0);
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mplier_q <= '0;
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef ALU_SEQ_MUL_EN
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
`endif
        end
    end

    assign in_ready         = (state_q == S_IDLE);
    assign out_valid        = (state_q == S_DONE);
    assign busy             = (state_q != S_IDLE);
    assign operation_output = result_q;
    assign zero             = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes expected result/zero/latency, monitor pops on out_valid.
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation_control;
    logic [31:0] source_A;
    logic [31:0] source_B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operation_output;
    logic        zero;
    logic        busy;

    alu_seq #(.WIDTH(32), .OP_WIDTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .operation_control (operation_control),
        .source_A          (source_A),
        .source_B          (source_B),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .operation_output  (operation_output),
        .zero              (zero),
        .busy              (busy)
    );

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   seen     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per out_valid presentation.
    always @(negedge clk) begin
        if (reset) begin
            seen = 0;
        end else if (out_valid && !seen) begin
            seen = 1;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%08h with no operation pending", operation_output);
            end else begin
                e = sb.pop_front();
                chk("result", operation_output, e.res);
                chk("zero", {31'b0, zero}, {31'b0, e.z});
                chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end else if (!out_valid) begin
            seen = 0;
        end
    end

    // Caller is at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input bit push);
        int w;
        operation_control = op;
        source_A          = a;
        source_B          = b;
        in_valid          = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready=%0b, expected 1", in_ready);
        end else if (push) begin
            sb.push_back('{res, (res == 32'h0), lat, cyc + 1});
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || busy) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
        end
        @(negedge clk);
    endtask

    initial begin
        reset             = 1'b1;
        in_valid          = 1'b0;
        out_ready         = 1'b1;
        operation_control = 4'h0;
        source_A          = 32'h0;
        source_B          = 32'h0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_output", operation_output, 32'h0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // ADD wrap; out_valid the cycle after accept, in_ready the cycle after that.
        issue(4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1);
        chk("add_out_valid", {31'b0, out_valid}, 32'd1);
        chk("add_in_ready_low", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        chk("add_in_ready_back", {31'b0, in_ready}, 32'd1);

        issue(4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 1);
        issue(4'b1000, 32'hFFFF_FFFF, 32'h1, 32'h1, 1, 1);
        issue(4'b1001, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1);
        issue(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1, 1);
        issue(4'b0001, 32'hF000_0000, 32'h0000_0001, 32'hF000_0001, 1, 1);
        issue(4'b0011, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1, 1);
        issue(4'b1111, 32'h1234_5678, 32'h1, 32'h0, 1, 1);
        drain();

        // Shifts.
        issue(4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000, 5, 1);
        drain();
        issue(4'b0100, 32'h1, 32'd0, 32'h1, 1, 1);
        drain();
        issue(4'b0101, 32'h8000_0000, 32'd31, 32'h1, 32, 1);
        drain();
        issue(4'b0100, 32'h3, 32'h21, 32'h6, 2, 1);
        drain();
        issue(4'b0111, 32'h4000_0000, 32'd2, 32'h1000_0000, 3, 1);
        drain();

        // Backpressure: result held, in_ready low, extra in_valid ignored.
        out_ready = 1'b0;
        issue(4'b0010, 32'd2, 32'd3, 32'd5, 1, 1);
        operation_control = 4'b0010;
        source_A          = 32'd9;
        source_B          = 32'd9;
        in_valid          = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_result", operation_output, 32'd5);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
        chk("bp_release_busy", {31'b0, busy}, 32'd0);

        // Reset mid-shift: no result may appear.
        issue(4'b0100, 32'h1, 32'd20, 32'h0, 21, 0);
        chk("shift_busy", {31'b0, busy}, 32'd1);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_output", operation_output, 32'h0);
        chk("midrst_zero", {31'b0, zero}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(4'b0010, 32'd1, 32'd1, 32'd2, 1, 1);
        drain();

`ifdef ALU_SEQ_MUL_EN
        issue(4'b1010, 32'd7, 32'd6, 32'd42, 33, 1);
        drain();
        issue(4'b1010, 32'h0001_0000, 32'h0001_0000, 32'h0, 33, 1);
        drain();
        issue(4'b1010, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 33, 1);
        drain();
`else
        issue(4'b1010, 32'd7, 32'd6, 32'h0, 1, 1);
        drain();
`endif

        // Back-to-back issue with out_ready high.
        issue(4'b0010, 32'd10, 32'd20, 32'd30, 1, 1);
        issue(4'b0110, 32'd10, 32'd20, 32'hFFFF_FFF6, 1, 1);
        drain();

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
